// File: rtl/rvfi_commit_sequencer.sv
// Merges the multi-port RVFI commit stream into one ordered, sequence-tagged
// stream for a single trace consumer. Also owns the sim cycle counter/timeout.
module rvfi_commit_sequencer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned ENTRY_W         = 256,
    parameter int unsigned DEPTH           = 8,
    localparam int unsigned PW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned OW = AW + 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NR_COMMIT_PORTS-1:0]         commit_valid_i,
    input  logic [NR_COMMIT_PORTS*ENTRY_W-1:0] commit_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [ENTRY_W-1:0]                 out_data_o,
    output logic [PW-1:0]                      out_port_o,
    output logic [31:0]                        out_seq_o,
    output logic [OW-1:0]                      occupancy_o,
    output logic                               overflow_o,
    output logic [31:0]                        drop_cnt_o,
    input  logic [31:0]                        timeout_limit_i,
    output logic [31:0]                        cycle_cnt_o,
    output logic                               timeout_o
);

    logic [ENTRY_W-1:0] data_q [DEPTH];
    logic [PW-1:0]      port_q [DEPTH];
    logic [31:0]        sqn_q  [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [31:0]   seq_q, seq_d;
    logic [31:0]   drop_q, drop_d;
    logic [31:0]   cyc_q, cyc_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;

    logic          pop;
    logic [OW:0]   free;
    logic [OW:0]   acc;
    logic [31:0]   ndrop;
    logic [32:0]   drop_sum;
    logic          wr_en  [NR_COMMIT_PORTS];
    logic [AW-1:0] wr_idx [NR_COMMIT_PORTS];
    logic [31:0]   wr_seq [NR_COMMIT_PORTS];

    assign out_valid_o = (occ_q != '0);
    assign out_data_o  = data_q[rd_ptr_q];
    assign out_port_o  = port_q[rd_ptr_q];
    assign out_seq_o   = sqn_q[rd_ptr_q];
    assign occupancy_o = occ_q;
    assign overflow_o  = ovf_q;
    assign drop_cnt_o  = drop_q;
    assign cycle_cnt_o = cyc_q;
    assign timeout_o   = tmo_q;

    always_comb begin
        pop   = out_valid_o & out_ready_i;
        // A same-cycle pop frees its slot for this cycle's pushes.
        free  = (OW+1)'(DEPTH) - {1'b0, occ_q} + (OW+1)'(pop);
        acc   = '0;
        ndrop = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            wr_en[i]  = 1'b0;
            wr_idx[i] = wr_ptr_q + acc[AW-1:0];
            wr_seq[i] = seq_q + 32'(acc);
            if (commit_valid_i[i]) begin
                if (acc < free) begin
                    wr_en[i] = 1'b1;
                    acc      = acc + (OW+1)'(1);
                end else begin
                    ndrop = ndrop + 32'd1;
                end
            end
        end

        wr_ptr_d = wr_ptr_q + acc[AW-1:0];
        rd_ptr_d = rd_ptr_q + AW'(pop);
        occ_d    = occ_q + acc[OW-1:0] - OW'(pop);
        seq_d    = seq_q + 32'(acc);

        drop_sum = {1'b0, drop_q} + {1'b0, ndrop};
        drop_d   = drop_sum[32] ? '1 : drop_sum[31:0];
        ovf_d    = ovf_q | (ndrop != '0);

        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
        tmo_d = tmo_q | (cyc_q > timeout_limit_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            seq_q    <= '0;
            drop_q   <= '0;
            cyc_q    <= '0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            seq_q    <= seq_d;
            drop_q   <= drop_d;
            cyc_q    <= cyc_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    // Storage needs no reset: contents are only observed while occupancy != 0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (wr_en[i]) begin
                data_q[wr_idx[i]] <= commit_data_i[i*ENTRY_W +: ENTRY_W];
                port_q[wr_idx[i]] <= PW'(i);
                sqn_q[wr_idx[i]]  <= wr_seq[i];
            end
        end
    end

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Bench for rvfi_commit_sequencer: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_rvfi_commit_sequencer;

    localparam int NP = 2;
    localparam int EW = 256;
    localparam int D  = 8;

    logic             clk;
    logic             rst_n;
    logic [NP-1:0]    valid;
    logic [NP*EW-1:0] data;
    logic             ready;
    logic [31:0]      limit;

    logic          out_valid;
    logic [EW-1:0] out_data;
    logic [0:0]    out_port;
    logic [31:0]   out_seq;
    logic [3:0]    occ;
    logic          ovf;
    logic [31:0]   drop;
    logic [31:0]   cyc;
    logic          tmo;

    rvfi_commit_sequencer #(
        .NR_COMMIT_PORTS(NP),
        .ENTRY_W(EW),
        .DEPTH(D)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .commit_valid_i(valid),
        .commit_data_i(data),
        .out_valid_o(out_valid),
        .out_ready_i(ready),
        .out_data_o(out_data),
        .out_port_o(out_port),
        .out_seq_o(out_seq),
        .occupancy_o(occ),
        .overflow_o(ovf),
        .drop_cnt_o(drop),
        .timeout_limit_i(limit),
        .cycle_cnt_o(cyc),
        .timeout_o(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [EW-1:0] d;
        int unsigned   port;
        logic [31:0]   seq;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_seq;
    longint      m_drop;
    longint      m_cyc;
    bit          m_ovf;
    bit          m_tmo;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] rnd();
        logic [EW-1:0] r;
        for (int i = 0; i < EW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a plain queue of records; one retire per cycle at most.
    always @(posedge clk or negedge rst_n) begin : model
        int   room;
        bit   pop;
        rec_t r;
        if (!rst_n) begin
            mq.delete();
            m_seq  = 0;
            m_drop = 0;
            m_cyc  = 0;
            m_ovf  = 0;
            m_tmo  = 0;
        end else begin
            pop  = (mq.size() != 0) && ready;
            room = D - mq.size() + (pop ? 1 : 0);
            if (pop) void'(mq.pop_front());
            for (int p = 0; p < NP; p++) begin
                if (valid[p]) begin
                    if (room > 0) begin
                        r.d  = data[p*EW +: EW];
                        r.port = p;
                        r.seq  = m_seq;
                        mq.push_back(r);
                        m_seq = m_seq + 1;
                        room--;
                    end else begin
                        m_drop++;
                        m_ovf = 1;
                    end
                end
            end
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
            if (m_cyc > longint'(limit)) m_tmo = 1;
            if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("data", out_data, mq[0].d);
                chk("port", out_port, mq[0].port);
                chk("seq", out_seq, mq[0].seq);
            end
            chk("occ", occ, mq.size());
            chk("ovf", ovf, m_ovf);
            chk("drop", drop, m_drop);
            chk("cyc", cyc, m_cyc);
            chk("tmo", tmo, m_tmo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; asserts reset asynchronously mid-cycle.
    task automatic do_reset();
        valid = '0;
        ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_occ", occ, 4'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_drop", drop, 32'd0);
        chk("rst_cyc", cyc, 32'd0);
        chk("rst_tmo", tmo, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [EW-1:0] a, b;

    initial begin
        rst_n = 1'b0;
        valid = '0;
        data  = '0;
        ready = 1'b0;
        limit = 32'd10;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        cmp_en = 1;

        // Cycle counter / timeout from reset release.
        ready = 1'b1;
        repeat (11) step();
        chk("cyc11", cyc, 32'd11);
        chk("tmo_at11", tmo, 1'b0);
        step();
        chk("cyc12", cyc, 32'd12);
        chk("tmo_at12", tmo, 1'b1);
        step();
        chk("tmo_sticky", tmo, 1'b1);

        // Both ports in one cycle: A then B.
        do_reset();
        a = rnd();
        b = rnd();
        ready = 1'b1;
        valid = 2'b11;
        data  = {b, a};
        step();
        valid = '0;
        chk("sp_valid", out_valid, 1'b1);
        chk("sp_a", out_data, a);
        chk("sp_a_port", out_port, 1'b0);
        chk("sp_a_seq", out_seq, 32'd0);
        step();
        chk("sp_b", out_data, b);
        chk("sp_b_port", out_port, 1'b1);
        chk("sp_b_seq", out_seq, 32'd1);
        step();
        chk("sp_empty", occ, 4'd0);
        chk("sp_novalid", out_valid, 1'b0);

        // Port 1 only, three cycles.
        do_reset();
        ready = 1'b1;
        valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            a = rnd();
            data = {a, rnd()};
            step();
            chk("sparse_data", out_data, a);
            chk("sparse_port", out_port, 1'b1);
            chk("sparse_seq", out_seq, 32'(k));
        end
        valid = '0;
        chk("sparse_drop", drop, 32'd0);

        // Overflow under backpressure, push/pop at full, then mid-stream reset.
        do_reset();
        ready = 1'b0;
        valid = 2'b11;
        repeat (5) begin
            data = {rnd(), rnd()};
            step();
        end
        valid = '0;
        chk("ovf_occ", occ, 4'd8);
        chk("ovf_drop", drop, 32'd2);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_head", out_seq, 32'd0);
        ready = 1'b1;
        valid = 2'b01;
        data  = {rnd(), rnd()};
        step();
        valid = '0;
        chk("full_pp_occ", occ, 4'd8);
        chk("full_pp_drop", drop, 32'd2);
        chk("full_pp_head", out_seq, 32'd1);
        repeat (4) step();
        chk("mid_occ", occ, 4'd4);
        chk("mid_head", out_seq, 32'd5);
        do_reset();
        ready = 1'b0;
        valid = 2'b10;
        data  = {rnd(), rnd()};
        step();
        valid = '0;
        chk("post_rst_seq", out_seq, 32'd0);
        chk("post_rst_port", out_port, 1'b1);
        chk("post_rst_occ", occ, 4'd1);

        // Randomized traffic alternating light and heavy backpressure.
        for (int i = 0; i < 3000; i++) begin
            valid = NP'($urandom);
            data  = {rnd(), rnd()};
            ready = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 30 : 85));
            step();
        end
        valid = '0;
        ready = 1'b1;
        repeat (D + 2) step();
        chk("final_empty", occ, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
